inc16: RTL and testbench

INC16 -- requirements
Module: inc16

---
 rtl/inc16_pkg.sv | 10 +
 rtl/inc16_if.sv | 38 +++
 rtl/inc16_half_adder.sv | 13 +
 rtl/inc16.sv | 50 +++++
 tb/tb_inc16.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/inc16_pkg.sv
// rtl/inc16_pkg.sv - shared width and constants for the incrementer
package inc16_pkg;

  // Default data width of the incrementer datapath
  localparam int INC16_WIDTH = 16;

  // Operand value that wraps to zero and raises carry
  localparam logic [INC16_WIDTH-1:0] INC16_ALL_ONES = '1;

endpackage

// File: rtl/inc16_if.sv
// rtl/inc16_if.sv - operand/result bundle for the incrementer
interface inc16_if
  import inc16_pkg::*;
#(
  parameter int WIDTH = INC16_WIDTH
) ();

  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic             carry;
  logic             en;
  logic [WIDTH-1:0] q;
  logic             q_carry;
  logic             q_valid;

  // Driver side: supplies the operand and load strobe, observes results
  modport master (
    output in,
    output en,
    input  out,
    input  carry,
    input  q,
    input  q_carry,
    input  q_valid
  );

  // Incrementer side: consumes the operand, produces results
  modport slave (
    input  in,
    input  en,
    output out,
    output carry,
    output q,
    output q_carry,
    output q_valid
  );

endinterface

// File: rtl/inc16_half_adder.sv
// rtl/inc16_half_adder.sv - single-bit half adder cell of the ripple chain
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  // Sum and carry of two bits
  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/inc16.sv
// rtl/inc16.sv - ripple-carry incrementer with an optional registered stage
module inc16
  import inc16_pkg::*;
#(
  parameter int WIDTH = INC16_WIDTH
) (
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             carry,
  output logic [WIDTH-1:0] q,
  output logic             q_carry,
  output logic             q_valid
);

  // c[i] is the carry into bit i; bit 0 adds the constant one
  logic [WIDTH:0] c;

  assign c[0] = 1'b1;

  // Ripple chain: each bit adds its operand bit to the carry from below
  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    half_adder u_ha (
      .a     (in[i]),
      .b     (c[i]),
      .sum   (out[i]),
      .carry (c[i+1])
    );
  end

  assign carry = c[WIDTH];

  // Registered copy of the result; reset wins over a load on the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q       <= '0;
      q_carry <= 1'b0;
      q_valid <= 1'b0;
    end else if (en) begin
      q       <= out;
      q_carry <= carry;
      q_valid <= 1'b1;
    end else begin
      q_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inc16.sv
// tb/tb_inc16.sv - scoreboard bench for the incrementer
module tb_inc16;
  import inc16_pkg::*;

  localparam int W = INC16_WIDTH;

  typedef struct packed {
    logic [W-1:0] out;
    logic         carry;
  } comb_exp_t;

  typedef struct packed {
    logic [W-1:0] q;
    logic         q_carry;
    logic         q_valid;
  } reg_exp_t;

  logic clk = 1'b0;
  logic clk_run = 1'b1;
  logic rst_n;
  int   compared = 0;
  int   mismatched = 0;

  comb_exp_t comb_sb[$];
  reg_exp_t  reg_sb[$];

  logic [W-1:0] model_q;
  logic         model_qc;

  inc16_if #(.WIDTH(W)) bus ();

  inc16 #(.WIDTH(W)) dut (
    .in      (bus.in),
    .out     (bus.out),
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (bus.en),
    .carry   (bus.carry),
    .q       (bus.q),
    .q_carry (bus.q_carry),
    .q_valid (bus.q_valid)
  );

  // Clock toggles only while clk_run is set
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference increment: 17-bit sum splits into result and carry
  function automatic comb_exp_t inc_model(input logic [W-1:0] v);
    logic [W:0] s;
    s = {1'b0, v} + 1;
    return '{out: s[W-1:0], carry: s[W]};
  endfunction

  task automatic drive_comb(input logic [W-1:0] v);
    comb_exp_t e;
    bus.in = v;
    comb_sb.push_back(inc_model(v));
    #1;
    e = comb_sb.pop_front();
    check($sformatf("out[%h]", v), 32'(bus.out), 32'(e.out));
    check($sformatf("carry[%h]", v), 32'(bus.carry), 32'(e.carry));
  endtask

  // Drive at negedge, predict the registered state, compare after the edge
  task automatic drive_reg(input string tag, input logic r, input logic e, input logic [W-1:0] v);
    reg_exp_t x;
    comb_exp_t m;
    @(negedge clk);
    rst_n  = r;
    bus.en = e;
    bus.in = v;
    m = inc_model(v);
    if (!r) begin
      model_q  = '0;
      model_qc = 1'b0;
    end else if (e) begin
      model_q  = m.out;
      model_qc = m.carry;
    end
    reg_sb.push_back('{q: model_q, q_carry: model_qc, q_valid: r & e});
    @(posedge clk);
    #1;
    x = reg_sb.pop_front();
    check({tag, ".q"}, 32'(bus.q), 32'(x.q));
    check({tag, ".q_carry"}, 32'(bus.q_carry), 32'(x.q_carry));
    check({tag, ".q_valid"}, 32'(bus.q_valid), 32'(x.q_valid));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] pats [10];
    pats = '{16'h0000, 16'h0001, 16'h0002, 16'hFFFF, 16'h7FFF,
             16'hAAAA, 16'h5555, 16'hFF00, 16'h00FF, 16'h8001};
    model_q  = '0;
    model_qc = 1'b0;
    rst_n  = 1'b0;
    bus.en = 1'b1;
    bus.in = 16'h1234;

    // Reset held for two clocks, with en high to show reset priority
    drive_reg("rst1", 1'b0, 1'b1, 16'h1234);
    drive_reg("rst2", 1'b0, 1'b1, 16'h1234);
    check("out_in_reset", 32'(bus.out), 32'h1235);

    // Combinational path with the clock stopped low
    @(negedge clk);
    clk_run = 1'b0;
    foreach (pats[i]) drive_comb(pats[i]);
    drive_comb(INC16_ALL_ONES);
    for (int i = 0; i < 8; i++) drive_comb(W'($urandom));
    clk_run = 1'b1;

    // Wrap-around load, then hold with en low
    drive_reg("load_ffff", 1'b1, 1'b1, 16'hFFFF);
    check("load_ffff.q_exact", 32'(bus.q), 32'h0000);
    check("load_ffff.qc_exact", 32'(bus.q_carry), 32'h1);
    drive_reg("hold", 1'b1, 1'b0, 16'h1234);
    check("hold.q_valid_exact", 32'(bus.q_valid), 32'h0);

    // Operand changes just after the edge; q keeps the edge value
    drive_reg("edge_cap", 1'b1, 1'b1, 16'h0010);
    bus.in = 16'h0020;
    #1;
    check("edge_cap.q_after", 32'(bus.q), 32'h0011);

    // Reset mid-stream discards the load, first load after release works
    drive_reg("rst_mid", 1'b0, 1'b1, 16'h0005);
    drive_reg("post_rst", 1'b1, 1'b1, 16'h00FE);
    check("post_rst.q_exact", 32'(bus.q), 32'h00FF);

    // Random stream of loads, holds and occasional resets
    for (int i = 0; i < 30; i++) begin
      drive_reg($sformatf("rnd%0d", i), ($urandom_range(0, 9) != 0),
                1'($urandom), W'($urandom));
    end

    if (comb_sb.size() != 0 || reg_sb.size() != 0)
      check("sb_empty", 32'(comb_sb.size() + reg_sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
